// File: rtl/branch_compare_unit.sv
// Multi-cycle branch comparator: walks WIDTH-bit operands SLICE bits per cycle from the
// MSB slice and resolves the RISC-V EQ/NE/LT/GE/LTU/GEU conditions, with optional early exit.
module branch_compare_unit #(
  parameter int WIDTH      = 32,
  parameter int SLICE      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             done,
  output logic             result,
  output logic             equal,
  output logic             less_s,
  output logic             less_u,
  output logic             illegal
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(NSLICE - 1);
  localparam logic [SLICE-1:0] MSB_MASK = SLICE'(1) << (SLICE - 1);

  localparam logic [2:0] M_EQ  = 3'b000;
  localparam logic [2:0] M_NE  = 3'b001;
  localparam logic [2:0] M_LT  = 3'b100;
  localparam logic [2:0] M_GE  = 3'b101;
  localparam logic [2:0] M_LTU = 3'b110;
  localparam logic [2:0] M_GEU = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b;
  logic [2:0]       r_mode;
  logic [IDX_W-1:0] r_idx;
  logic             r_diff, r_lt_s, r_lt_u;
  logic             r_result, r_equal, r_less_s, r_less_u, r_illegal;

  logic             w_accept, w_last, w_first;
  logic [SLICE-1:0] w_sa, w_sb;
  logic             w_diff, w_lt_u, w_lt_s;
  logic             w_done, w_result, w_illegal;

  assign w_accept = start && (r_state == S_IDLE) && !flush;

  // Current slice; the top slice is compared in offset-binary form to get the signed order.
  assign w_sa   = r_a[int'(r_idx)*SLICE +: SLICE];
  assign w_sb   = r_b[int'(r_idx)*SLICE +: SLICE];
  assign w_diff = (w_sa != w_sb);
  assign w_lt_u = (w_sa < w_sb);
  assign w_lt_s = (r_idx == TOP_IDX) ? ((w_sa ^ MSB_MASK) < (w_sb ^ MSB_MASK)) : w_lt_u;

  assign w_first = w_diff && !r_diff;
  assign w_last  = (r_idx == '0) || ((EARLY_EXIT != 0) && w_diff);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
      S_BUSY:  if (flush) w_state_nxt = S_IDLE;
               else if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_illegal = (r_mode == 3'b010) || (r_mode == 3'b011);

  always_comb begin
    w_result = 1'b0;
    case (r_mode)
      M_EQ:    w_result = !r_diff;
      M_NE:    w_result = r_diff;
      M_LT:    w_result = r_lt_s;
      M_GE:    w_result = !r_lt_s;
      M_LTU:   w_result = r_lt_u;
      M_GEU:   w_result = !r_lt_u;
      default: w_result = 1'b0;
    endcase
  end

  // Fresh fields are presented only with an unflushed done; otherwise the last reported set holds.
  assign w_done  = (r_state == S_DONE) && !flush;
  assign ready   = (r_state == S_IDLE);
  assign done    = w_done;
  assign result  = w_done ? w_result  : r_result;
  assign equal   = w_done ? !r_diff   : r_equal;
  assign less_s  = w_done ? r_lt_s    : r_less_s;
  assign less_u  = w_done ? r_lt_u    : r_less_u;
  assign illegal = w_done ? w_illegal : r_illegal;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_mode    <= '0;
      r_idx     <= '0;
      r_diff    <= 1'b0;
      r_lt_s    <= 1'b0;
      r_lt_u    <= 1'b0;
      r_result  <= 1'b0;
      r_equal   <= 1'b0;
      r_less_s  <= 1'b0;
      r_less_u  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_mode <= mode;
        r_idx  <= TOP_IDX;
        r_diff <= 1'b0;
        r_lt_s <= 1'b0;
        r_lt_u <= 1'b0;
      end else if ((r_state == S_BUSY) && !flush) begin
        if (w_first) begin
          r_diff <= 1'b1;
          r_lt_s <= w_lt_s;
          r_lt_u <= w_lt_u;
        end
        if (!w_last) r_idx <= r_idx - 1'b1;
      end
      if (w_done) begin
        r_result  <= w_result;
        r_equal   <= !r_diff;
        r_less_s  <= r_lt_s;
        r_less_u  <= r_lt_u;
        r_illegal <= w_illegal;
      end
    end
  end

endmodule

// File: tb/tb_branch_compare_unit.sv
// Bench for branch_compare_unit: three instances (32/8 early-exit, 32/8 fixed latency, 8/8 single
// slice) driven with directed and random compares and checked against an arithmetic model.
module tb_branch_compare_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_v, flush_v;
  logic [2:0]  mode_v [3];
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  wire  [2:0]  ready_v, done_v, result_v, equal_v, less_s_v, less_u_v, illegal_v;

  int          n_vec = 0;
  int          n_err = 0;
  logic [4:0]  held_v [3];   // last reported {result, equal, less_s, less_u, illegal}

  always #5 clk = ~clk;

  branch_compare_unit #(.WIDTH(32), .SLICE(8), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode_v[0]), .a(a_v[0]), .b(b_v[0]),
    .flush(flush_v[0]), .ready(ready_v[0]), .done(done_v[0]), .result(result_v[0]),
    .equal(equal_v[0]), .less_s(less_s_v[0]), .less_u(less_u_v[0]), .illegal(illegal_v[0]));

  branch_compare_unit #(.WIDTH(32), .SLICE(8), .EARLY_EXIT(0)) dut_fixed (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode_v[1]), .a(a_v[1]), .b(b_v[1]),
    .flush(flush_v[1]), .ready(ready_v[1]), .done(done_v[1]), .result(result_v[1]),
    .equal(equal_v[1]), .less_s(less_s_v[1]), .less_u(less_u_v[1]), .illegal(illegal_v[1]));

  branch_compare_unit #(.WIDTH(8), .SLICE(8), .EARLY_EXIT(1)) dut_one (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode_v[2]), .a(a_v[2][7:0]),
    .b(b_v[2][7:0]), .flush(flush_v[2]), .ready(ready_v[2]), .done(done_v[2]),
    .result(result_v[2]), .equal(equal_v[2]), .less_s(less_s_v[2]), .less_u(less_u_v[2]),
    .illegal(illegal_v[2]));

  function automatic logic [4:0] obs(input int sel);
    return {result_v[sel], equal_v[sel], less_s_v[sel], less_u_v[sel], illegal_v[sel]};
  endfunction

  // Reference: whole-word arithmetic; latency from the highest differing bit position.
  function automatic void model(input int sel, input logic [2:0] mode, input logic [31:0] a_in,
                                input logic [31:0] b_in, output logic [4:0] f, output int lat);
    int          w  = (sel == 2) ? 8 : 32;
    int          ns = w / 8;
    bit          ee = (sel != 1);
    logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    logic [31:0] sbit = 32'd1 << (w - 1);
    logic [31:0] a = a_in & mask;
    logic [31:0] b = b_in & mask;
    logic [31:0] x = a ^ b;
    logic        eq = (a == b);
    logic        lu = (a < b);
    logic        ls = ((a ^ sbit) < (b ^ sbit));
    logic        il = (mode == 3'd2) || (mode == 3'd3);
    logic        res;
    int          p = 0;
    case (mode)
      3'd0: res = eq;    3'd1: res = !eq;
      3'd4: res = ls;    3'd5: res = !ls;
      3'd6: res = lu;    3'd7: res = !lu;
      default: res = 1'b0;
    endcase
    f = {res, eq, ls, lu, il};
    for (int i = 0; i < 32; i++) if (x[i]) p = i;
    lat = (!ee || eq) ? ns + 1 : ns - p / 8 + 1;
  endfunction

  // One compare on instance sel; optional extra start pulse in cycle restart_cyc (0 = none).
  task automatic test_compare(input int sel, input logic [2:0] mode, input logic [31:0] a,
                              input logic [31:0] b, input int restart_cyc, input string tag);
    logic [4:0] exp_f, got_f;
    int         lat, first, cnt;
    logic       rdy;
    model(sel, mode, a, b, exp_f, lat);
    got_f = 'x; first = -1; cnt = 0; rdy = 1'b0;
    @(negedge clk);
    a_v[sel] = a; b_v[sel] = b; mode_v[sel] = mode; start_v[sel] = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= lat + 6; cyc++) begin
      @(negedge clk);
      start_v[sel] = (cyc == restart_cyc);
      a_v[sel] = $urandom; b_v[sel] = $urandom;
      if (done_v[sel]) begin
        cnt++;
        if (first < 0) begin first = cyc; got_f = obs(sel); end
      end
      if (cyc == lat + 1) rdy = ready_v[sel];
    end
    start_v[sel] = 1'b0;
    n_vec += 4;
    if (first !== lat) begin
      n_err++; $display("FAIL %s latency: done cycle %0d, want %0d", tag, first, lat);
    end
    if (cnt !== 1) begin
      n_err++; $display("FAIL %s done_count: got %0d, want 1", tag, cnt);
    end
    if (got_f !== exp_f) begin
      n_err++; $display("FAIL %s fields{res,eq,lts,ltu,ill}: got %b, want %b", tag, got_f, exp_f);
    end
    if (rdy !== 1'b1) begin
      n_err++; $display("FAIL %s ready_after: got %b, want 1", tag, rdy);
    end
    held_v[sel] = exp_f;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_v = '0; flush_v = '0;
    for (int s = 0; s < 3; s++) begin mode_v[s] = '0; a_v[s] = '0; b_v[s] = '0; held_v[s] = '0; end
    #12;
    for (int s = 0; s < 3; s++) begin
      n_vec++;
      if ({ready_v[s], done_v[s], obs(s)} !== 7'b1000000) begin
        n_err++; $display("FAIL reset[%0d] {ready,done,fields}: got %b, want 1000000",
                          s, {ready_v[s], done_v[s], obs(s)});
      end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed;
    test_compare(0, 3'd0, 32'h1234_5678, 32'h1234_5678, 0, "eq_equal");
    test_compare(0, 3'd4, 32'h8000_0000, 32'h0000_0001, 0, "lt_top");
    test_compare(0, 3'd6, 32'h8000_0000, 32'h0000_0001, 0, "ltu_top");
    test_compare(0, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "geu_low");
    test_compare(1, 3'd1, 32'h0100_0000, 32'h0000_0000, 0, "ne_fixed");
    test_compare(2, 3'd4, 32'h0000_0080, 32'h0000_007F, 0, "lt_one_slice");
    test_compare(2, 3'd0, 32'h0000_005A, 32'h0000_005A, 0, "eq_one_slice");
  endtask

  task automatic test_back_to_back;
    test_compare(0, 3'd2, 32'd3, 32'd3, 2, "illegal_restart");
    test_compare(0, 3'd3, 32'd5, 32'd9, 0, "illegal_011");
  endtask

  task automatic test_flush;
    int cnt = 0;
    logic rdy;
    @(negedge clk);
    a_v[0] = 32'hCAFE_F00D; b_v[0] = 32'hCAFE_F00D; mode_v[0] = 3'd0; start_v[0] = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      flush_v[0] = (cyc == 2);
      if (cyc == 3) rdy = ready_v[0];
      if (done_v[0]) cnt++;
    end
    n_vec += 3;
    if (cnt !== 0) begin n_err++; $display("FAIL flush_busy done_count: got %0d, want 0", cnt); end
    if (rdy !== 1'b1) begin n_err++; $display("FAIL flush_busy ready: got %b, want 1", rdy); end
    if (obs(0) !== held_v[0]) begin
      n_err++; $display("FAIL flush_busy fields: got %b, want %b", obs(0), held_v[0]);
    end
    // start together with flush while idle must be dropped
    cnt = 0;
    a_v[0] = 32'd1; b_v[0] = 32'd2; mode_v[0] = 3'd6; start_v[0] = 1'b1; flush_v[0] = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start_v[0] = 1'b0; flush_v[0] = 1'b0;
      if (cyc == 1) rdy = ready_v[0];
      if (done_v[0]) cnt++;
    end
    n_vec += 3;
    if (cnt !== 0) begin n_err++; $display("FAIL flush_idle done_count: got %0d, want 0", cnt); end
    if (rdy !== 1'b1) begin n_err++; $display("FAIL flush_idle ready: got %b, want 1", rdy); end
    if (obs(0) !== held_v[0]) begin
      n_err++; $display("FAIL flush_idle fields: got %b, want %b", obs(0), held_v[0]);
    end
  endtask

  task automatic test_async_reset;
    int cnt = 0;
    @(negedge clk);
    a_v[0] = 32'h0F0F_0F0F; b_v[0] = 32'h0F0F_0F0F; mode_v[0] = 3'd0; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ready_v[0], done_v[0], obs(0)} !== 7'b1000000) begin
      n_err++; $display("FAIL async_reset {ready,done,fields}: got %b, want 1000000",
                        {ready_v[0], done_v[0], obs(0)});
    end
    for (int s = 0; s < 3; s++) held_v[s] = '0;
    @(negedge clk); rst_n = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (done_v[0]) cnt++;
    end
    n_vec++;
    if (cnt !== 0) begin n_err++; $display("FAIL async_reset done_after: got %0d, want 0", cnt); end
    test_compare(0, 3'd5, 32'h7FFF_FFFF, 32'h8000_0000, 0, "after_reset_ge");
  endtask

  task automatic test_random;
    logic [2:0]  modes [8] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};
    logic [31:0] a, b;
    int          sel;
    for (int n = 0; n < 48; n++) begin
      sel = (n < 28) ? 0 : (n < 38) ? 1 : 2;
      a = $urandom;
      case ($urandom % 4)
        0: b = $urandom;
        1: b = a;
        2: b = a ^ (32'd1 << ($urandom % 32));
        default: b = a ^ {$urandom_range(1, 255), 24'd0};
      endcase
      if (sel == 2 && (n % 3 == 0)) b = a ^ (32'd1 << ($urandom % 8));
      test_compare(sel, modes[$urandom % 8], a, b, 0, $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_compare_unit.md
Name: branch_compare_unit

Overview:
- Parametrised, multi-cycle successor to the 32-bit combinational equality comparator used for branch resolution.
- Compares two WIDTH-bit operands SLICE bits per cycle, starting at the MSB slice. Supports six RISC-V branch conditions (EQ/NE/LT/GE/LTU/GEU) and optionally exits early at the first differing slice.
- Sits beside the ID-stage branch logic. Uses a start/ready/done handshake and a flush input, so a redirect can abort an in-flight compare.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of SLICE.
- SLICE, 8, bits compared per BUSY cycle. NSLICE = WIDTH/SLICE (derived, 1..64).
- EARLY_EXIT, 1. When 1, the unit finishes after the first differing slice. When 0, it always walks all NSLICE slices, giving fixed latency.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted when start && ready && !flush
- mode  in  3  branch condition, latched at accept: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 illegal
- a  in  WIDTH  operand A, latched at accept
- b  in  WIDTH  operand B, latched at accept
- flush  in  1  synchronous abort of any in-flight compare
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse; result fields valid in that cycle
- result  out  1  branch-taken for the latched mode
- equal  out  1  a == b
- less_s  out  1  a < b, two's-complement
- less_u  out  1  a < b, unsigned
- illegal  out  1  latched mode was 010/011; valid with done

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (rst_n low, async): state=IDLE, slice index=0, op registers=0.
  - Outputs: ready=1, done=0, result=0, equal=0, less_s=0, less_u=0, illegal=0.
  - Reset mid-BUSY/DONE discards the operation; no done is issued.
- IDLE: on accept, latch a, b and mode; idx=NSLICE-1; clear the diff-found flag; go to BUSY. ready=0 from the next cycle.
- BUSY, one slice per cycle at idx:
  - The top slice (idx=NSLICE-1) is compared with its MSB inverted (signed view) for less_s; all slices are compared unsigned for less_u.
  - On the first differing slice, record eq=0 and the lt_s/lt_u of that slice. Later slices never overwrite this.
  - Leave BUSY (to DONE) when idx==0, or when EARLY_EXIT=1 and a difference was just found. Otherwise idx decrements.
- DONE, exactly one cycle:
  - done=1, with result/equal/less_s/less_u/illegal registered and valid.
  - Next state is IDLE; ready returns to 1 the following cycle.
  - Result fields hold their values until the next done. done is 0 outside DONE.
- Latency:
  - Start sampled at edge 0; done is high in cycle m+1, where m = number of slices examined.
  - m = NSLICE if operands are equal, or if EARLY_EXIT=0.
  - Otherwise m = position of the first differing slice counted from the MSB (1..NSLICE).
- result by mode:
  - EQ=equal, NE=!equal, LT=less_s, GE=!less_s, LTU=less_u, GEU=!less_u.
  - Illegal mode: result=0, illegal=1, but equal/less_s/less_u are still computed normally.
- NSLICE=1: single BUSY cycle; done in cycle 2.
- flush:
  - In BUSY or DONE: next state IDLE; done is forced 0 that cycle; result fields keep their previous values.
  - flush together with start in IDLE: start is ignored.
- Handshake: start while !ready is ignored; it is not queued. Operand changes after accept have no effect.

Test Plan:
- WIDTH=32, SLICE=8, EARLY_EXIT=1; a=b=0x12345678, mode EQ, start at cycle 0 -> done high in cycle 5 only; result=1, equal=1, less_s=0, less_u=0; ready=1 in cycle 6.
- a=0x80000000, b=0x00000001, mode LT -> differs in top slice; done in cycle 2; result=1, less_s=1, less_u=0. Repeat with mode LTU -> result=0.
- a=0xFFFFFFFF, b=0xFFFFFFFE, mode GEU -> done in cycle 5, result=1, less_u=0. With EARLY_EXIT=0 and a=0x01000000, b=0, mode NE -> done still in cycle 5, result=1.
- Start at cycle 0 with equal operands, flush in cycle 2 -> no done pulse; ready=1 in cycle 3. start+flush together in IDLE -> ready stays 1, no done; prior result fields unchanged.
- mode=010, a=3, b=3 -> done in cycle 5; illegal=1, result=0, equal=1. Start pulsed again in cycle 2 -> ignored, exactly one done.
- rst_n low asynchronously in cycle 3 of a BUSY compare -> ready=1 and all outputs 0 immediately, before the next clock edge; no done after release. A new start then completes normally.
